pixel_stream_gen: RTL

//  Raster-scan pixel source: transmit side of the pixel stream consumed by cluster.
//  On start, emits one full IMG_WIDTH x IMG_HEIGHT frame, row-major, as pixel_r/g/b, pixel_valid, x, y.

---
 rtl/pixel_stream_gen.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_stream_gen.sv
// Raster-scan pixel source: one IMG_WIDTH x IMG_HEIGHT frame per start, background plus three square markers.
// Optional pixel noise (16-bit LFSR, clamped) is enabled by defining PIXEL_STREAM_GEN_NOISE_EN.
module pixel_stream_gen #(
  parameter int          IMG_WIDTH  = 640,
  parameter int          IMG_HEIGHT = 480,
  parameter int          MARK_SIZE  = 4,
  parameter int          BG_VAL     = 300,
  parameter logic [35:0] COLOR0     = {12'd50, 12'd100, 12'd150},
  parameter logic [35:0] COLOR1     = {12'd450, 12'd500, 12'd550},
  parameter logic [35:0] COLOR2     = {12'd900, 12'd950, 12'd1000},
  localparam int         XW         = $clog2(IMG_WIDTH),
  localparam int         YW         = $clog2(IMG_HEIGHT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [XW-1:0]      cx0,
  input  logic [XW-1:0]      cx1,
  input  logic [XW-1:0]      cx2,
  input  logic [YW-1:0]      cy0,
  input  logic [YW-1:0]      cy1,
  input  logic [YW-1:0]      cy2,
  input  logic               ready,
  output logic signed [11:0] pixel_r,
  output logic signed [11:0] pixel_g,
  output logic signed [11:0] pixel_b,
  output logic               pixel_valid,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               busy,
  output logic               frame_done
);

  // Handshake: a pixel transfers (beat) on a cycle where pixel_valid & ready; without a beat
  // every pixel output holds; ready is ignored while pixel_valid is low.

  localparam int CW = ((XW > YW) ? XW : YW) + $clog2(MARK_SIZE) + 2;
  localparam logic signed [CW-1:0] HALF = CW'(MARK_SIZE / 2);
  localparam logic [35:0] BG_RGB = {12'(BG_VAL), 12'(BG_VAL), 12'(BG_VAL)};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0][XW-1:0]  cx_q, cx_d;
  logic [2:0][YW-1:0]  cy_q, cy_d;
  logic [XW-1:0]       nx;
  logic [YW-1:0]       ny;
  logic                nvalid, ndone, load_rgb, zero_rgb;
  logic                beat, last_pix;
  logic [2:0]          hit;
  logic [35:0]         ideal_rgb, pix_d;

  // Signed, widened compare so regions clip cleanly at both frame edges.
  function automatic logic in_span(input logic signed [CW-1:0] p, input logic signed [CW-1:0] c);
    return (p >= c - HALF) && (p <= c + HALF - CW'(1));
  endfunction

  assign beat     = pixel_valid & ready;
  assign last_pix = (x == XW'(IMG_WIDTH - 1)) && (y == YW'(IMG_HEIGHT - 1));

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    nx       = x;
    ny       = y;
    nvalid   = pixel_valid;
    ndone    = 1'b0;
    load_rgb = 1'b0;
    zero_rgb = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cx_d     = {cx2, cx1, cx0};
          cy_d     = {cy2, cy1, cy0};
          nx       = '0;
          ny       = '0;
          nvalid   = 1'b1;
          load_rgb = 1'b1;
        end
      end
      S_RUN: begin
        if (beat) begin
          if (last_pix) begin
            state_d  = S_DONE;
            nx       = '0;
            ny       = '0;
            nvalid   = 1'b0;
            ndone    = 1'b1;
            zero_rgb = 1'b1;
          end else begin
            if (x == XW'(IMG_WIDTH - 1)) begin
              nx = '0;
              ny = y + YW'(1);
            end else begin
              nx = x + XW'(1);
            end
            load_rgb = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Colour is chosen from the next coordinates and next centres so it lines up with x,y.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      hit[k] = in_span(CW'(nx), CW'(cx_d[k])) && in_span(CW'(ny), CW'(cy_d[k]));
    end
    if (hit[0])      ideal_rgb = COLOR0;
    else if (hit[1]) ideal_rgb = COLOR1;
    else if (hit[2]) ideal_rgb = COLOR2;
    else             ideal_rgb = BG_RGB;
  end

`ifdef PIXEL_STREAM_GEN_NOISE_EN
  localparam logic [15:0] SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d;

  function automatic logic [11:0] add_noise(input logic [11:0] v, input logic [2:0] n);
    logic signed [13:0] s;
    s = $signed({2'b00, v}) + $signed({11'b0, n}) - 14'sd4;
    if (s < 0)              return 12'd0;
    else if (s > 14'sd2047) return 12'd2047;
    else                    return s[11:0];
  endfunction

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == S_IDLE && start)
      lfsr_d = SEED;
    else if (state_q == S_RUN && beat)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    pix_d = {add_noise(ideal_rgb[35:24], lfsr_d[2:0]),
             add_noise(ideal_rgb[23:12], lfsr_d[6:4]),
             add_noise(ideal_rgb[11:0],  lfsr_d[10:8])};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign pix_d = ideal_rgb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      x           <= '0;
      y           <= '0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      pixel_r     <= '0;
      pixel_g     <= '0;
      pixel_b     <= '0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      x           <= nx;
      y           <= ny;
      pixel_valid <= nvalid;
      busy        <= (state_d == S_RUN);
      frame_done  <= ndone;
      if (zero_rgb) begin
        pixel_r <= '0;
        pixel_g <= '0;
        pixel_b <= '0;
      end else if (load_rgb) begin
        pixel_r <= pix_d[35:24];
        pixel_g <= pix_d[23:12];
        pixel_b <= pix_d[11:0];
      end
    end
  end

endmodule
